// File: rtl/press_gen_pkg.sv
// Shared FSM state encodings and default 50 MHz timing constants for the
// push-button press generator.
package press_gen_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;

  // 50 ms at 50 MHz, comfortably longer than a 40 ms debounce window
  localparam int   DEF_HOLD_CYCLES = 2_500_000;
  localparam int   DEF_GAP_CYCLES  = 2_500_000;
  localparam int   DEF_CNT_W       = 22;
  localparam int   DEF_Q_W         = 3;
  localparam logic DEF_IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/press_generator_if.sv
// Request/status bundle between a press requester and the press generator.
interface press_generator_if #(
  parameter int Q_W = 3
);

  logic           press_req;
  logic           level_out;
  logic           busy;
  logic [Q_W-1:0] pending;
  logic           overflow;

  modport master (
    output press_req,
    input  level_out, busy, pending, overflow
  );

  modport slave (
    input  press_req,
    output level_out, busy, pending, overflow
  );

endinterface

// File: rtl/sat_updown_counter.sv
// Saturating up/down counter; an increment that would wrap is dropped and
// flagged with a one-cycle registered sat_drop pulse.
module sat_updown_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             sat_drop
);

  localparam logic [WIDTH-1:0] MAX = '1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      sat_drop <= 1'b0;
    end else begin
      sat_drop <= 1'b0;
      if (inc && !dec) begin
        if (count == MAX) sat_drop <= 1'b1;
        else              count    <= count + 1'b1;
      end else if (dec && !inc && count != '0) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/press_generator.sv
// Turns one-cycle press requests into debounce-safe button pulses: a hold
// phase, then an idle gap, with extra requests queued in a saturating counter.
module press_generator
  import press_gen_pkg::*;
#(
  parameter int   HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int   GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int   CNT_W       = DEF_CNT_W,
  parameter int   Q_W         = DEF_Q_W,
  parameter logic IDLE_LEVEL  = DEF_IDLE_LEVEL
) (
  input  logic             clk,
  input  logic             reset_n,
  press_generator_if.slave bus
);

  logic [1:0]       state;
  logic [CNT_W-1:0] phase_cnt;
  logic [Q_W-1:0]   pending_cnt;
  logic             level_q;
  logic             busy_q;
  logic             overflow_q;
  logic             consume;
  logic             has_pending;
  logic             hold_done;
  logic             gap_done;

  assign has_pending = (pending_cnt != '0);
  assign hold_done   = (phase_cnt == CNT_W'(HOLD_CYCLES - 1));
  assign gap_done    = (phase_cnt == CNT_W'(GAP_CYCLES - 1));

  // A press is taken from the queue only when the line is free to start one
  always_comb begin
    consume = 1'b0;
    case (state)
      ST_IDLE: consume = has_pending;
      ST_GAP:  consume = gap_done && has_pending;
      default: consume = 1'b0;
    endcase
  end

  sat_updown_counter #(
    .WIDTH(Q_W)
  ) u_pending (
    .clk      (clk),
    .reset_n  (reset_n),
    .inc      (bus.press_req),
    .dec      (consume),
    .count    (pending_cnt),
    .sat_drop (overflow_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      phase_cnt <= '0;
      level_q   <= IDLE_LEVEL;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (consume) begin
            state     <= ST_ACTIVE;
            phase_cnt <= '0;
            level_q   <= ~IDLE_LEVEL;
            busy_q    <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (hold_done) begin
            state     <= ST_GAP;
            phase_cnt <= '0;
            level_q   <= IDLE_LEVEL;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_done) begin
            phase_cnt <= '0;
            if (consume) begin
              state   <= ST_ACTIVE;
              level_q <= ~IDLE_LEVEL;
            end else begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          phase_cnt <= '0;
          level_q   <= IDLE_LEVEL;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.level_out = level_q;
  assign bus.busy      = busy_q;
  assign bus.pending   = pending_cnt;
  assign bus.overflow  = overflow_q;

endmodule
